// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/flag stalls, taken-branch flushes,
// a small RUN/LU_STALL/BR_FLUSH state machine and saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_flag_use,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_flagen,
    input  logic             mem_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_BR_FLUSH = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic       w_legal;
    logic       w_lu_haz;
    logic       w_fl_haz;
    logic       w_br;
    logic       w_stall;
    logic [1:0] w_next_state;

    assign w_legal  = (r_state != 2'd3);
    assign w_lu_haz = ex_memread & (ex_rd != 5'd31) &
                      ((id_use_rn & (id_rn == ex_rd)) | (id_use_rm & (id_rm == ex_rd)));
    assign w_fl_haz = id_flag_use & ex_flagen;
    // MEM holds a squashed bubble during BR_FLUSH, so its branch signal is ignored.
    assign w_br     = w_legal & mem_br_taken & (r_state != ST_BR_FLUSH);
    assign w_stall  = w_legal & ~w_br & (w_lu_haz | w_fl_haz);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = 1'b0;
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_br) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_sel      = 1'b1;
        end else if (w_stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Every legal state shares one transition rule once br already excludes BR_FLUSH.
    always_comb begin
        w_next_state = ST_RUN;
        if (w_br)
            w_next_state = ST_BR_FLUSH;
        else if (w_stall)
            w_next_state = ST_LU_STALL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_br && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_use_rn, id_use_rm, id_flag_use, ex_memread, ex_flagen, mem_br_taken;

    logic        pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic       s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pc_sel;
    logic [1:0] s_state;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    int m_state;
    int m_stall, m_flush, m_stall_s, m_flush_s;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_flag_use(id_flag_use), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_flagen(ex_flagen), .mem_br_taken(mem_br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pc_sel(pc_sel),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .id_flag_use(id_flag_use), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_flagen(ex_flagen), .mem_br_taken(mem_br_taken),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .pc_sel(s_pc_sel),
        .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel}
    localparam logic [5:0] C_NORM  = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b111111;
    localparam logic [5:0] C_RST   = 6'b001110;

    typedef struct {
        logic [4:0] rn, rm, rd;
        logic       use_rn, use_rm, flag_use, memread, flagen, br;
        logic [5:0] exp_ctl;
        int         exp_state, exp_stall, exp_flush;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [5:0] ctl_main();
        return {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pc_sel};
    endfunction

    function automatic logic [5:0] ctl_small();
        return {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_exmem_flush, s_pc_sel};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic urn, input logic urm, input logic fu,
                         input logic mr, input logic fe, input logic br);
        id_rn = rn; id_rm = rm; ex_rd = rd;
        id_use_rn = urn; id_use_rm = urm; id_flag_use = fu;
        ex_memread = mr; ex_flagen = fe; mem_br_taken = br;
    endtask

    // Reference rules evaluated straight from the current inputs and model state.
    function automatic bit m_branch();
        return rst && mem_br_taken && (m_state != 2);
    endfunction

    function automatic bit m_hazard();
        bit lu, fl;
        lu = ex_memread && (ex_rd != 31) &&
             ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
        fl = id_flag_use && ex_flagen;
        return rst && !m_branch() && (lu || fl);
    endfunction

    function automatic logic [5:0] m_ctl();
        if (!rst) return C_RST;
        if (m_branch()) return C_BR;
        if (m_hazard()) return C_STALL;
        return C_NORM;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Called right before the active edge.
    task automatic model_edge();
        if (!rst) begin
            m_state = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
        end else begin
            bit b, h;
            b = m_branch();
            h = m_hazard();
            if (h) begin
                m_stall   = sat(m_stall + 1, 65535);
                m_stall_s = sat(m_stall_s + 1, 3);
            end
            if (b) begin
                m_flush   = sat(m_flush + 1, 65535);
                m_flush_s = sat(m_flush_s + 1, 3);
            end
            m_state = b ? 2 : (h ? 1 : 0);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic step_model(input string tag);
        #1;
        check({tag, "_ctl"}, ctl_main(), m_ctl());
        check({tag, "_ctl_s"}, ctl_small(), m_ctl());
        model_edge();
        @(posedge clk);
        #1;
        check({tag, "_state"}, state, m_state);
        check({tag, "_stall"}, stall_cnt, m_stall);
        check({tag, "_flush"}, flush_cnt, m_flush);
        check({tag, "_stall_s"}, s_stall_cnt, m_stall_s);
        check({tag, "_flush_s"}, s_flush_cnt, m_flush_s);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        //               rn rm rd urn urm fu mr fe br  ctl      st stl fl
        tbl[0]  = '{5'd3, 5'd0, 5'd3, 1, 0, 0, 1, 0, 0, C_STALL, 1, 1, 0};
        tbl[1]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_NORM,  0, 1, 0};
        tbl[2]  = '{5'd0, 5'd31, 5'd31, 0, 1, 0, 1, 0, 0, C_NORM, 0, 1, 0};
        tbl[3]  = '{5'd3, 5'd0, 5'd3, 1, 0, 0, 1, 0, 1, C_BR,    2, 1, 1};
        tbl[4]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, C_NORM,  0, 1, 1};
        tbl[5]  = '{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0, C_STALL, 1, 2, 1};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_NORM,  0, 2, 1};
        tbl[7]  = '{5'd4, 5'd5, 5'd5, 1, 0, 0, 1, 0, 0, C_NORM,  0, 2, 1};
        tbl[8]  = '{5'd4, 5'd5, 5'd5, 0, 1, 0, 1, 0, 0, C_STALL, 1, 3, 1};
        tbl[9]  = '{5'd4, 5'd5, 5'd5, 0, 1, 0, 1, 0, 0, C_STALL, 1, 4, 1};
        tbl[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, C_BR,    2, 4, 2};
        tbl[11] = '{5'd7, 5'd0, 5'd7, 1, 0, 0, 1, 0, 1, C_STALL, 1, 5, 2};
        tbl[12] = '{5'd7, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0, C_NORM,  0, 5, 2};

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_ctl", ctl_main(), C_RST);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rn, tbl[i].rm, tbl[i].rd, tbl[i].use_rn, tbl[i].use_rm,
                  tbl[i].flag_use, tbl[i].memread, tbl[i].flagen, tbl[i].br);
            #1;
            check($sformatf("tbl%0d_ctl", i), ctl_main(), tbl[i].exp_ctl);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
            check($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].exp_stall);
            check($sformatf("tbl%0d_flush", i), flush_cnt, tbl[i].exp_flush);
        end

        // Saturation on the 2-bit instance: held load-use gives 1,2,3,3,3.
        do_reset();
        drive(5'd3, 5'd0, 5'd3, 1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d_cnt", k), s_stall_cnt, (k < 2) ? k + 1 : 3);
            check($sformatf("sat%0d_state", k), s_state, 1);
        end

        // Asynchronous reset while in BR_FLUSH.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        check("mid_pre_state", state, 2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_state", state, 0);
        check("mid_rst_flush", flush_cnt, 0);
        check("mid_rst_ctl", ctl_main(), C_RST);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rel_ctl", ctl_main(), C_NORM);
        @(posedge clk);
        #1;
        check("mid_rel_state", state, 0);

        // Randomized traffic with occasional reset pulses.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] pool[4];
            pool[0] = 5'd1; pool[1] = 5'd2; pool[2] = 5'd31; pool[3] = 5'($urandom);
            drive(pool[$urandom_range(3)], pool[$urandom_range(3)], pool[$urandom_range(3)],
                  1'($urandom), 1'($urandom), 1'($urandom_range(3) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom_range(2) == 0));
            rst = ($urandom_range(39) != 0);
            step_model($sformatf("rnd%0d", c));
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage pipelined CPU. It watches register and flag dependencies between ID and EX, and taken branches resolved in MEM. From these it drives the PC/IF_ID write-enables, the bubble-insertion flushes for IF_ID, ID_EX and EX_MEM, and the branch-target select into the PC mux. A small state machine and saturating event counters sit alongside the combinational control, for bench and debug visibility.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rn  in  5  ID-stage first source register (instr[9:5]).
- id_rm  in  5  ID-stage second source register, taken after the Reg2Loc mux.
- id_use_rn  in  1  ID instruction reads id_rn.
- id_use_rm  in  1  ID instruction reads id_rm.
- id_flag_use  in  1  ID instruction is a flag-consuming branch (BLT).
- ex_rd  in  5  destination register in ID_EX.
- ex_memread  in  1  MemRead bit in ID_EX.
- ex_flagen  in  1  FlagEn bit in ID_EX.
- mem_br_taken  in  1  branch-taken signal from the MEM-stage branch logic.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF_ID write enable.
- ifid_flush  out  1  load a NOP into IF_ID at the next edge.
- idex_flush  out  1  zero the ID_EX control fields at the next edge.
- exmem_flush  out  1  zero the EX_MEM control fields at the next edge.
- pc_sel  out  1  1 selects the branch target (addr_EX_MEM); 0 selects PC+4.
- state  out  2  current FSM state: 0 RUN, 1 LU_STALL, 2 BR_FLUSH.
- stall_cnt  out  CNT_W  count of bubble cycles inserted for load-use or flag hazards.
- flush_cnt  out  CNT_W  count of taken-branch flushes.

## Operation
Hazard terms (combinational):
- lu_haz = ex_memread & (ex_rd != 31) & ((id_use_rn & id_rn == ex_rd) | (id_use_rm & id_rm == ex_rd)). X31 (XZR) never creates a hazard.
- fl_haz = id_flag_use & ex_flagen.
- br = mem_br_taken & (state != BR_FLUSH).

Output priority: br first, then lu_haz | fl_haz, then normal.
- br: pc_sel=1, pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1. A simultaneous stall condition is discarded, because the instruction in ID is squashed.
- Stall (lu_haz | fl_haz, no br): pc_en=0, ifid_en=0, idex_flush=1, everything else 0.
- Normal: pc_en=1, ifid_en=1, all flushes 0, pc_sel=0.

FSM (next state is evaluated each edge):
- RUN → BR_FLUSH on br; → LU_STALL on a stall; otherwise stays in RUN.
- LU_STALL → BR_FLUSH on br; → LU_STALL on a new stall (back-to-back stalls are allowed); otherwise → RUN.
- BR_FLUSH → LU_STALL on a stall; otherwise → RUN. This lasts exactly one cycle. In this state mem_br_taken is ignored, because MEM holds the flushed bubble.
- State encoding 3 is illegal; the FSM recovers to RUN on the next edge with normal outputs.

Counters:
- stall_cnt increments by 1 on every edge where a stall is output.
- flush_cnt increments by 1 on every edge where br is true.
- Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Control outputs are combinational from the inputs and state, with zero-cycle latency. They must settle within the same cycle so they act at the next edge.
- state, stall_cnt and flush_cnt are registered and update at the rising edge.
- Load-use penalty is exactly 1 bubble; the dependent instruction reaches EX one cycle after the load reaches MEM.
- Taken-branch penalty is exactly 3 squashed instructions: those in IF_ID, ID_EX and EX_MEM at the flush edge. The target is fetched in the following cycle.
- While rst is low: state=RUN, stall_cnt=0, flush_cnt=0. Control outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1, pc_sel=0.
- Reset asserted mid-stall or mid-flush aborts immediately, with no pending effect after release.
- The first edge after rst rises behaves as RUN.

## Test plan
- Load-use: ex_memread=1, ex_rd=3, id_rn=3, id_use_rn=1 → pc_en=0, ifid_en=0, idex_flush=1 for one cycle; state=1 next; stall_cnt=1. Inputs then clear → state=0.
- XZR exemption: ex_memread=1, ex_rd=31, id_rm=31, id_use_rm=1 → no stall; pc_en=1; stall_cnt stays 0.
- Branch with concurrent load-use: mem_br_taken=1 together with lu_haz=1 → pc_sel=1, all three flushes=1, pc_en=1; state=2; flush_cnt=1; stall_cnt=0. Holding mem_br_taken=1 the next cycle → pc_sel=0, flush_cnt still 1.
- Flag hazard: id_flag_use=1, ex_flagen=1 → 1-cycle stall. Then id_flag_use=1, ex_flagen=0 → no stall.
- Saturation with CNT_W=2: hold lu_haz for 5 cycles → stall_cnt sequence 1,2,3,3,3; state remains 1.
- Reset mid-operation: drop rst while state=2 → state=0, counters=0, pc_en=0, flushes=1 immediately (asynchronous). Release rst → normal outputs.
